// File: rtl/inpmem_reader.sv
// Read-side initiator for the banked input memory: streams LENGTH consecutive words from
// BASE_ADDR into a valid/ready stream through a 2-entry credit-managed output buffer.
module inpmem_reader #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic              mem_cen,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_a,
   input  logic [DATA_W-1:0] mem_q,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

   state_e              state_q, state_d;
   logic [LEN_W-1:0]    len_q, issue_cnt_q;
   logic [ADDR_W-1:0]   addr_q, mem_a_q;
   logic                inflight_q, inflight_last_q;
   logic [DATA_W-1:0]   buf_data_q [2];
   logic [1:0]          buf_last_q;
   logic                wr_ptr_q, rd_ptr_q;
   logic [1:0]          count_q;

   logic                pop, issue, last_issue;
   logic [1:0]          occ;

   // A word popped this cycle frees its slot, which keeps one word per cycle flowing.
   assign pop        = out_valid & out_ready;
   assign occ        = count_q + {1'b0, inflight_q} - {1'b0, pop};
   assign issue      = (state_q == StRead) && (occ < 2'd2);
   assign last_issue = (issue_cnt_q == len_q - LEN_W'(1));

   assign mem_cen   = ~issue;
   assign mem_wen   = 1'b1;
   assign mem_a     = issue ? addr_q : mem_a_q;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = buf_data_q[rd_ptr_q];
   assign out_last  = out_valid & buf_last_q[rd_ptr_q];
   assign busy      = (state_q == StRead) || (state_q == StDrain);
   assign done      = (state_q == StFin);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = (length != '0) ? StRead : StFin;
         StRead:  if (issue && last_issue) state_d = StDrain;
         StDrain: if (pop && out_last) state_d = StFin;
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= StIdle;
         len_q           <= '0;
         issue_cnt_q     <= '0;
         addr_q          <= '0;
         mem_a_q         <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         buf_data_q[0]   <= '0;
         buf_data_q[1]   <= '0;
         buf_last_q      <= '0;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start) begin
            len_q       <= length;
            addr_q      <= base_addr;
            issue_cnt_q <= '0;
         end
         if (issue) begin
            addr_q      <= addr_q + ADDR_W'(1);
            mem_a_q     <= addr_q;
            issue_cnt_q <= issue_cnt_q + LEN_W'(1);
         end
         inflight_q      <= issue;
         inflight_last_q <= issue & last_issue;
         // Read data is valid the cycle after issue; capture it into the tail slot.
         if (inflight_q) begin
            buf_data_q[wr_ptr_q] <= mem_q;
            buf_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q             <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
      end
   end

endmodule
